// File: rtl/mux_scan_ctrl_if.sv
// Signal bundle between a mux scanner and the environment that owns the mux.
// The scanner side uses the slave modport; the mux/stimulus side uses master.
interface mux_scan_ctrl_if #(
  parameter int DWELL_W = 4
) ();
  logic               start;
  logic [DWELL_W-1:0] dwell;
  logic               mux_y;
  logic               s0;
  logic               s1;
  logic [3:0]         sample;
  logic               busy;
  logic               done;

  modport master (
    output start,
    output dwell,
    output mux_y,
    input  s0,
    input  s1,
    input  sample,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  dwell,
    input  mux_y,
    output s0,
    output s1,
    output sample,
    output busy,
    output done
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scans a downstream 4-to-1 mux: holds each select for dwell+1 cycles, captures
// mux_y into sample[idx] on the last cycle of each channel, then pulses done.
module mux_scan_ctrl #(
  parameter int DWELL_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_scan_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

  state_t             state, state_n;
  logic [1:0]         idx, idx_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [DWELL_W-1:0] dwell_q, dwell_n;
  logic [1:0]         sel, sel_n;
  logic [3:0]         sample_q, sample_n;

  // State register and datapath registers share one asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 2'd0;
      cnt      <= '0;
      dwell_q  <= '0;
      sel      <= 2'd0;
      sample_q <= 4'b0000;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      dwell_q  <= dwell_n;
      sel      <= sel_n;
      sample_q <= sample_n;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    cnt_n    = cnt;
    dwell_n  = dwell_q;
    sel_n    = sel;
    sample_n = sample_q;

    case (state)
      IDLE: begin
        sel_n = 2'd0;
        if (bus.start) begin
          state_n  = SETTLE;
          idx_n    = 2'd0;
          cnt_n    = '0;
          dwell_n  = bus.dwell;
          sel_n    = 2'd0;
          sample_n = 4'b0000;
        end
      end

      SETTLE: begin
        if (cnt == dwell_q) begin
          sample_n[idx] = bus.mux_y;
          cnt_n         = '0;
          if (idx == 2'd3) begin
            // Last channel: park the selects and finish instead of wrapping.
            state_n = DONE;
            sel_n   = 2'd0;
          end else begin
            idx_n = idx + 2'd1;
            sel_n = idx + 2'd1;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      DONE: begin
        state_n = IDLE;
        sel_n   = 2'd0;
      end

      default: begin
        state_n = IDLE;
        sel_n   = 2'd0;
      end
    endcase
  end

  assign bus.s0     = sel[1];
  assign bus.s1     = sel[0];
  assign bus.sample = sample_q;
  assign bus.busy   = (state == SETTLE);
  assign bus.done   = (state == DONE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: directed scan scenarios plus randomized traffic,
// all checked each cycle against a scan-timeline reference model.
module tb_mux_scan_ctrl;

  localparam int DWELL_W = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [DWELL_W-1:0] dwell = '0;
  logic [3:0]         ch = 4'b0000;   // ch[0]=a, ch[1]=b, ch[2]=c, ch[3]=d

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: position in the scan timeline, counted in edges since acceptance.
  int         m_e = -1;
  int         m_d = 0;
  logic [3:0] m_sample = 4'b0000;

  mux_scan_ctrl_if #(.DWELL_W(DWELL_W)) bus ();

  assign bus.start = start;
  assign bus.dwell = dwell;
  assign bus.mux_y = ch[{bus.s0, bus.s1}];

  mux_scan_ctrl #(.DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int per();
    return m_d + 1;
  endfunction

  task automatic model_edge();
    if (m_e < 0) begin
      if (start) begin
        m_e      = 0;
        m_d      = int'(dwell);
        m_sample = 4'b0000;
      end
    end else begin
      m_e++;
      if (m_e <= 4 * per() && (m_e % per()) == 0)
        m_sample[m_e / per() - 1] = ch[m_e / per() - 1];
      if (m_e > 4 * per())
        m_e = -1;
    end
  endtask

  task automatic check_outputs();
    logic       e_busy, e_done;
    logic [1:0] e_sel;
    e_busy = (m_e >= 0) && (m_e < 4 * per());
    e_done = (m_e == 4 * per());
    e_sel  = e_busy ? 2'(m_e / per()) : 2'd0;
    check("busy",   32'(bus.busy),           32'(e_busy));
    check("done",   32'(bus.done),           32'(e_done));
    check("select", 32'({bus.s0, bus.s1}),   32'(e_sel));
    check("sample", 32'(bus.sample),         32'(m_sample));
  endtask

  // One clock edge; inputs were set before the call and stay stable across the edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_outputs();
  endtask

  task automatic apply_reset();
    #1;
    rst_n = 1'b0;
    #1;
    m_e      = -1;
    m_d      = 0;
    m_sample = 4'b0000;
    check("rst_busy",   32'(bus.busy),         32'd0);
    check("rst_done",   32'(bus.done),         32'd0);
    check("rst_select", 32'({bus.s0, bus.s1}), 32'd0);
    check("rst_sample", 32'(bus.sample),       32'd0);
    tick();
    tick();
    #2;
    rst_n = 1'b1;
  endtask

  // Pulse start once and run to the done pulse; optionally re-pulse start with dwell=7 mid-scan.
  task automatic scan(input logic [3:0] d, input logic [3:0] c, input int poke_at,
                      output int lat, output int busy_n, output int done_n);
    dwell = d;
    ch    = c;
    start = 1'b1;
    tick();
    start  = 1'b0;
    lat    = 0;
    busy_n = int'(bus.busy);
    done_n = 0;
    while (!bus.done && lat < 300) begin
      if (lat == poke_at) begin
        start = 1'b1;
        dwell = 4'd7;
      end
      tick();
      start = 1'b0;
      lat++;
      busy_n += int'(bus.busy);
    end
    check("scan_reached_done", 32'(lat < 300), 32'd1);
    done_n = int'(bus.done);
    for (int k = 0; k < 3; k++) begin
      tick();
      done_n += int'(bus.done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, busy_n, done_n;
    int dones, first_done, last_done;

    apply_reset();
    tick();

    // a=1 b=0 c=1 d=0, dwell 0
    scan(4'd0, 4'b0101, -1, lat, busy_n, done_n);
    check("d0_latency", 32'(lat), 32'd4);
    check("d0_sample", 32'(bus.sample), 32'b0101);
    check("d0_done_count", 32'(done_n), 32'd1);

    // a=0 b=1 c=1 d=0, dwell 3
    scan(4'd3, 4'b0110, -1, lat, busy_n, done_n);
    check("d3_latency", 32'(lat), 32'd16);
    check("d3_busy_cycles", 32'(busy_n), 32'd16);
    check("d3_sample", 32'(bus.sample), 32'b0110);

    // Second start and dwell change during the scan are ignored
    scan(4'd2, 4'b1001, 3, lat, busy_n, done_n);
    check("ignore_latency", 32'(lat), 32'd12);
    check("ignore_done_count", 32'(done_n), 32'd1);
    check("ignore_sample", 32'(bus.sample), 32'b1001);

    // Reset mid-scan at idx 2, then a fresh scan with all inputs high
    dwell = 4'd1;
    ch    = 4'b0110;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("abort_at_idx2", 32'({bus.s0, bus.s1}), 32'd2);
    apply_reset();
    tick();
    check("abort_no_done", 32'(bus.done), 32'd0);
    scan(4'd1, 4'b1111, -1, lat, busy_n, done_n);
    check("post_reset_sample", 32'(bus.sample), 32'b1111);
    check("post_reset_latency", 32'(lat), 32'd8);

    // Start held high: back-to-back scans
    dwell      = 4'd0;
    ch         = 4'b1010;
    start      = 1'b1;
    dones      = 0;
    first_done = -1;
    last_done  = -1;
    for (int k = 0; k < 18; k++) begin
      tick();
      if (bus.done) begin
        dones++;
        if (first_done < 0) first_done = k;
        last_done = k;
      end
    end
    start = 1'b0;
    check("b2b_done_count", 32'(dones), 32'd3);
    check("b2b_done_span", 32'(last_done - first_done), 32'd12);
    for (int k = 0; k < 8; k++) tick();

    // Maximum dwell
    scan(4'hF, 4'b0011, -1, lat, busy_n, done_n);
    check("dmax_latency", 32'(lat), 32'd64);
    check("dmax_busy_cycles", 32'(busy_n), 32'd64);
    check("dmax_sample", 32'(bus.sample), 32'b0011);

    // Randomized traffic, checked every cycle by the model
    for (int k = 0; k < 1500; k++) begin
      ch    = 4'($urandom);
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) dwell = 4'hF;
      else                           dwell = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) apply_reset();
      else                             tick();
    end
    start = 1'b0;
    for (int k = 0; k < 80; k++) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
